// File: rtl/mci_sram_responder.sv
// Purpose : behavioural SRAM responder with configurable read latency, single/double-bit
//           error injection on read data, and saturating request counters.
// Latency : writes land at the request edge; read data appears RD_LATENCY cycles after the request.
// Backpressure: none; every request with req_cs=1 is accepted in its cycle.
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   req_cs/req_we       - request strobe and write enable (write when high)
//   req_addr/req_wdata  - word address and write word {ecc, data}
//   resp_rdata/rvalid   - read word and its one-cycle valid pulse
//   inj_sbe/inj_dbe     - arm a single/double-bit flip on the next read
//   rd_count/wr_count   - saturating counts of accepted reads/writes
module mci_sram_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_W     = 32,
    parameter int ECC_W      = 7,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_cs,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_W+ECC_W-1:0]   req_wdata,
    output logic [DATA_W+ECC_W-1:0]   resp_rdata,
    output logic                      resp_rvalid,
    input  logic                      inj_sbe,
    input  logic                      inj_dbe,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count
);

    localparam int W     = DATA_W + ECC_W;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("mci_sram_responder: RD_LATENCY must be in 1..4");
    end

    logic [W-1:0]            r_mem [DEPTH];
    logic [RD_LATENCY-1:0]   r_vld;
    logic [W-1:0]            r_dat [RD_LATENCY];
    logic                    r_sbe_armed;
    logic                    r_dbe_armed;
    logic [31:0]             r_rd_count;
    logic [31:0]             r_wr_count;

    logic                    w_rd;
    logic                    w_wr;
    logic                    w_sbe_eff;
    logic                    w_dbe_eff;
    logic [W-1:0]            w_err_mask;
    logic [W-1:0]            w_rd_word;

    // Requests seen at an edge while reset is held are dropped.
    assign w_rd = req_cs & ~req_we & ~rst;
    assign w_wr = req_cs &  req_we & ~rst;

    // A pulse arriving in the same cycle as a read is honoured by that read.
    assign w_sbe_eff = r_sbe_armed | inj_sbe;
    assign w_dbe_eff = r_dbe_armed | inj_dbe;

    always_comb begin
        w_err_mask = '0;
        if (w_dbe_eff) begin
            w_err_mask = W'(3);
        end else if (w_sbe_eff) begin
            w_err_mask = W'(1);
        end
    end

    // Corruption is applied on the read path only; storage keeps the clean word.
    assign w_rd_word = r_mem[req_addr] ^ w_err_mask;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[req_addr] <= req_wdata;
        end
    end

    // Any read consumes whatever is armed: DBE wins and clears both, otherwise
    // only SBE can be set and it is the one consumed. Writes leave flags alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sbe_armed <= 1'b0;
            r_dbe_armed <= 1'b0;
        end else if (w_rd) begin
            r_sbe_armed <= 1'b0;
            r_dbe_armed <= 1'b0;
        end else begin
            r_sbe_armed <= w_sbe_eff;
            r_dbe_armed <= w_dbe_eff;
        end
    end

    // Valid/data shift pipeline. A data stage only loads when the stage before
    // it is valid, so the last stage holds the previous result between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd;
            if (w_rd) begin
                r_dat[0] <= w_rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rd && (r_rd_count != 32'hFFFF_FFFF)) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign resp_rvalid = r_vld[RD_LATENCY-1];
    assign resp_rdata  = r_dat[RD_LATENCY-1];
    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_mci_sram_responder.sv
// Purpose : self-checking bench driving three responders (latency 1, 2, 3) with shared stimulus.
// Latency : expected read results are queued with the cycle they must appear in.
// Backpressure: none; a negedge monitor pops and compares every rvalid pulse.
module tb_mci_sram_responder;

    localparam int W = 39;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_cs;
    logic           req_we;
    logic [7:0]     req_addr;
    logic [W-1:0]   req_wdata;
    logic           inj_sbe;
    logic           inj_dbe;

    logic [W-1:0]   rdata0, rdata1, rdata2;
    logic           rvalid0, rvalid1, rvalid2;
    logic [31:0]    rdc0, rdc1, rdc2;
    logic [31:0]    wrc0, wrc1, wrc2;

    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    int             exp_rd = 0;
    int             exp_wr = 0;
    exp_t           q [3][$];
    logic [W-1:0]   last [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mci_sram_responder #(.RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_cs(req_cs), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_rdata(rdata0), .resp_rvalid(rvalid0),
        .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .rd_count(rdc0), .wr_count(wrc0));

    mci_sram_responder #(.RD_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_cs(req_cs), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_rdata(rdata1), .resp_rvalid(rvalid1),
        .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .rd_count(rdc1), .wr_count(wrc1));

    mci_sram_responder #(.RD_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req_cs(req_cs), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_rdata(rdata2), .resp_rvalid(rvalid2),
        .inj_sbe(inj_sbe), .inj_dbe(inj_dbe), .rd_count(rdc2), .wr_count(wrc2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic [W-1:0] d);
        exp_t e;
        if (rst) begin
            last[i] = '0;
        end else if (v) begin
            if (q[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid_L%0d: got rdata %0h with no read outstanding (cycle %0d)",
                         i + 1, d, cyc);
            end else begin
                e = q[i].pop_front();
                chk($sformatf("rdata_L%0d", i + 1), 64'(d), 64'(e.d));
                chk($sformatf("rvalid_cycle_L%0d", i + 1), 64'(cyc), 64'(e.c));
            end
            last[i] = d;
        end else begin
            chk($sformatf("rdata_hold_L%0d", i + 1), 64'(d), 64'(last[i]));
        end
    endtask

    always @(negedge clk) begin
        mon(0, rvalid0, rdata0);
        mon(1, rvalid1, rdata1);
        mon(2, rvalid2, rdata2);
    end

    task automatic drive(input logic cs, input logic we, input logic [7:0] a,
                         input logic [W-1:0] wd, input logic s, input logic d);
        @(negedge clk);
        req_cs    = cs;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        inj_sbe   = s;
        inj_dbe   = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [W-1:0] wd);
        drive(1'b1, 1'b1, a, wd, 1'b0, 1'b0);
        exp_wr++;
    endtask

    // expv is the hand-computed word the read must return.
    task automatic do_read(input logic [7:0] a, input logic [W-1:0] expv,
                           input logic s, input logic d);
        exp_t e;
        drive(1'b1, 1'b0, a, '0, s, d);
        for (int i = 0; i < 3; i++) begin
            e.d = expv;
            e.c = cyc + i + 1;
            q[i].push_back(e);
        end
        exp_rd++;
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, "_rd_L1"}, 64'(rdc0), 64'(exp_rd));
        chk({nm, "_rd_L2"}, 64'(rdc1), 64'(exp_rd));
        chk({nm, "_rd_L3"}, 64'(rdc2), 64'(exp_rd));
        chk({nm, "_wr_L1"}, 64'(wrc0), 64'(exp_wr));
        chk({nm, "_wr_L2"}, 64'(wrc1), 64'(exp_wr));
        chk({nm, "_wr_L3"}, 64'(wrc2), 64'(exp_wr));
    endtask

    initial begin
        rst = 1'b1;
        req_cs = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        inj_sbe = 1'b0; inj_dbe = 1'b0;
        for (int i = 0; i < 3; i++) last[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rvalid", 64'({rvalid0, rvalid1, rvalid2}), 64'(0));
        chk("reset_rdata_L1", 64'(rdata0), 64'(0));
        chk("reset_rdata_L3", 64'(rdata2), 64'(0));
        chk_counts("reset");
        rst = 1'b0;

        // Write then read on the very next cycle
        do_write(8'h10, 39'h55_DEAD_BEEF);
        do_read(8'h10, 39'h55_DEAD_BEEF, 1'b0, 1'b0);
        idle(4);
        chk_counts("first_rw");

        // Back-to-back reads of preloaded words
        do_write(8'h00, 39'hA0);
        do_write(8'h01, 39'hA1);
        do_write(8'h02, 39'hA2);
        do_write(8'h03, 39'hA3);
        do_read(8'h00, 39'hA0, 1'b0, 1'b0);
        do_read(8'h01, 39'hA1, 1'b0, 1'b0);
        do_read(8'h02, 39'hA2, 1'b0, 1'b0);
        do_read(8'h03, 39'hA3, 1'b0, 1'b0);
        idle(4);

        // SBE armed by a pulse, consumed by one read only
        do_write(8'h05, 39'h0);
        drive(1'b0, 1'b0, 8'h00, '0, 1'b1, 1'b0);
        idle(2);
        do_read(8'h05, 39'h1, 1'b0, 1'b0);
        do_read(8'h05, 39'h0, 1'b0, 1'b0);

        // Both armed together: DBE wins and both are cleared
        drive(1'b0, 1'b0, 8'h00, '0, 1'b1, 1'b1);
        do_read(8'h05, 39'h3, 1'b0, 1'b0);
        do_read(8'h05, 39'h0, 1'b0, 1'b0);

        // Arming in the same cycle as the read
        do_read(8'h05, 39'h1, 1'b1, 1'b0);
        do_read(8'h05, 39'h0, 1'b0, 1'b0);

        // A write does not consume an armed DBE
        drive(1'b0, 1'b0, 8'h00, '0, 1'b0, 1'b1);
        do_write(8'h06, 39'h7F_0000_0000);
        do_read(8'h06, 39'h7F_0000_0003, 1'b0, 1'b0);
        do_read(8'h06, 39'h7F_0000_0000, 1'b0, 1'b0);

        // Address/we/wdata are ignored while cs is low
        drive(1'b0, 1'b1, 8'h05, {W{1'b1}}, 1'b0, 1'b0);
        do_read(8'h05, 39'h0, 1'b0, 1'b0);
        idle(5);
        chk_counts("after_inject");
        for (int i = 0; i < 3; i++) chk($sformatf("drain_mid_L%0d", i + 1), 64'(q[i].size()), 64'(0));

        // Reset arriving one cycle after a read: only the latency-1 result escapes
        do_read(8'h10, 39'h55_DEAD_BEEF, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        q[1].delete();
        q[2].delete();
        exp_rd = 0;
        exp_wr = 0;
        req_cs = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = '0;
        @(negedge clk);
        chk("midrst_rvalid", 64'({rvalid0, rvalid1, rvalid2}), 64'(0));
        chk_counts("midrst");
        @(negedge clk);
        chk("midrst_rdata_L2", 64'(rdata1), 64'(0));
        rst = 1'b0;
        req_cs = 1'b0; req_we = 1'b0;
        idle(4);
        chk_counts("post_rst");
        do_read(8'h10, 39'h55_DEAD_BEEF, 1'b0, 1'b0);
        idle(5);
        chk_counts("post_rst_read");

        // Counter saturation
        @(negedge clk);
        force u_l1.r_rd_count = 32'hFFFF_FFFE;
        #1;
        release u_l1.r_rd_count;
        do_read(8'h10, 39'h55_DEAD_BEEF, 1'b0, 1'b0);
        do_read(8'h10, 39'h55_DEAD_BEEF, 1'b0, 1'b0);
        do_read(8'h10, 39'h55_DEAD_BEEF, 1'b0, 1'b0);
        idle(6);
        chk("rd_count_saturate", 64'(rdc0), 64'(32'hFFFF_FFFF));
        chk("rd_count_L2_after_sat", 64'(rdc1), 64'(4));
        for (int i = 0; i < 3; i++) chk($sformatf("drain_end_L%0d", i + 1), 64'(q[i].size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
